// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
    localparam int          DIV_WIDTH     = 16;
    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/rcas_16bit.sv
// 16-bit ripple-carry adder/subtractor; sel=1 computes a-b with c_out=1 when a>=b.
module rcas_16bit
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    input  logic                 sel,
    output logic [DIV_WIDTH-1:0] result,
    output logic                 c_out
);
    logic [DIV_WIDTH:0]   c;
    logic [DIV_WIDTH-1:0] bx;

    assign bx   = b ^ {DIV_WIDTH{sel}};
    assign c[0] = sel;

    for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_fa
        assign result[i] = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]    = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign c_out = c[DIV_WIDTH];
endmodule

// File: rtl/seq_div_16bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a
// shared subtractor, start/busy/done handshake, results held until the next start.
module seq_div_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q;
    logic [WIDTH-1:0] a_q, q_q, d_q;
    logic [CW-1:0]    count_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic [WIDTH:0]   s_d;
    logic [WIDTH-1:0] diff;
    logic             c_out;
    logic             ok;
    logic [WIDTH-1:0] a_d, q_d;

    // S[16] set means the shifted remainder already exceeds any 16-bit divisor.
    assign s_d = {a_q, q_q[WIDTH-1]};
    assign ok  = s_d[WIDTH] | c_out;
    assign a_d = ok ? diff : s_d[WIDTH-1:0];
    assign q_d = {q_q[WIDTH-2:0], ok};

    rcas_16bit u_rcas (
        .a      (s_d[WIDTH-1:0]),
        .b      (d_q),
        .sel    (1'b1),
        .result (diff),
        .c_out  (c_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quot_q  <= DIV_ZERO_QUOT;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            a_q     <= '0;
                            q_q     <= dividend;
                            d_q     <= divisor;
                            count_q <= CW'(WIDTH);
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_CALC;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        quot_q  <= q_d;
                        rem_q   <= a_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_16bit.sv
// Randomized and directed checks of seq_div_16bit against an arithmetic timing model.
module tb_seq_div_16bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    seq_div_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: a division occupies 16 cycles, then results appear with a done pulse.
    int          busy_left;
    logic        m_busy, m_done, m_dbz;
    logic [15:0] m_q, m_r, p_q, p_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left <= 0;
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            m_busy    <= (busy_left > 1);
            m_done    <= (busy_left == 1);
            if (busy_left == 1) begin
                m_q <= p_q;
                m_r <= p_r;
            end
        end else begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            if (start) begin
                if (divisor == 16'd0) begin
                    m_q <= 16'hFFFF; m_r <= dividend; m_dbz <= 1'b1; m_done <= 1'b1;
                end else begin
                    p_q <= dividend / divisor;
                    p_r <= dividend % divisor;
                    m_dbz <= 1'b0; m_busy <= 1'b1; busy_left <= 16;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("busy_and_done", {31'd0, busy & done}, 32'd0);
        chk("quotient", {16'd0, quotient}, {16'd0, m_q});
        chk("remainder", {16'd0, remainder}, {16'd0, m_r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
    end

    // Called at a negedge; issues a division and waits (bounded) for done.
    task automatic run_div(input logic [15:0] dv, input logic [15:0] ds, input int poke,
                           input logic [15:0] eq, input logic [15:0] er);
        int  lat  = -1;
        int  bcnt = 0;
        int  extra = 0;
        bit  got  = 0;
        start = 1'b1; dividend = dv; divisor = ds;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == poke) begin
                start = 1'b1; dividend = 16'($urandom); divisor = 16'($urandom);
            end
            if (busy) bcnt++;
            if (done) begin got = 1; lat = n; end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), (ds == 16'd0) ? 32'd0 : 32'd16);
            chk("busy_cycles", 32'(bcnt), (ds == 16'd0) ? 32'd0 : 32'd16);
            chk("res_quot", {16'd0, quotient}, {16'd0, eq});
            chk("res_rem", {16'd0, remainder}, {16'd0, er});
            chk("res_dbz", {31'd0, div_by_zero}, {31'd0, (ds == 16'd0)});
        end
        if (poke >= 0) begin
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) extra++;
            end
            chk("single_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] rdv, rds;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", {16'd0, quotient}, 32'd0);
        chk("rst_rem", {16'd0, remainder}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(16'd100, 16'd7, -1, 16'd14, 16'd2);
        repeat (2) @(negedge clk);
        run_div(16'hFFFF, 16'h8001, -1, 16'd1, 16'h7FFE);
        repeat (2) @(negedge clk);
        run_div(16'd5, 16'd0, -1, 16'hFFFF, 16'd5);
        repeat (2) @(negedge clk);
        run_div(16'h8000, 16'hFFFF, -1, 16'd0, 16'h8000);
        run_div(16'hFFFF, 16'd1, -1, 16'hFFFF, 16'd0);
        repeat (2) @(negedge clk);
        run_div(16'd1234, 16'd10, 5, 16'd123, 16'd4);

        for (int i = 0; i < 40; i++) begin
            rdv = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rds = 16'd0;
                1, 2, 3: rds = 16'($urandom_range(1, 300));
                default: rds = 16'($urandom);
            endcase
            run_div(rdv, rds, -1, (rds == 16'd0) ? 16'hFFFF : rdv / rds,
                    (rds == 16'd0) ? rdv : rdv % rds);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Abort mid-division; results from earlier runs must clear asynchronously.
        start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quot", {16'd0, quotient}, 32'd0);
        chk("abort_rem", {16'd0, remainder}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_div(16'd9, 16'd3, -1, 16'd3, 16'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
